// File: rtl/clm_round_ctrl_pkg.sv
// Shared types and constants for the masked-AES round controller.
package clm_round_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE,
      INIT,
      RAND,
      LOAD,
      SUB,
      LIN,
      DONE,
      ERR
   } rctrl_state_t;

   typedef logic [3:0] round_t;

   localparam int NR_AES128 = 10;
   localparam int NR_AES192 = 12;
   localparam int NR_AES256 = 14;

endpackage

// File: rtl/clm_rctrl_wdog.sv
// SUB-state watchdog: clear/increment counter flagging WDOG_CYCLES stalled cycles.
// Only built when CLM_RCTRL_WDOG_EN is defined.
`ifdef CLM_RCTRL_WDOG_EN
module clm_rctrl_wdog #(
   parameter int WDOG_CYCLES = 64
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic inc,
   output logic expired
);

   localparam int CW = $clog2(WDOG_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(WDOG_CYCLES - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (inc && cnt != LAST) begin
         cnt <= cnt + CW'(1);
      end
   end

   // Fires on the stalled cycle that would take the count past its limit.
   assign expired = inc && (cnt == LAST);

endmodule
`endif

// File: rtl/clm_round_ctrl.sv
// Round sequencer for the masked AES datapath: RNG fetch, SubBytes, linear layer, key step.
// Optional SUB-state watchdog and ERR state under CLM_RCTRL_WDOG_EN.
module clm_round_ctrl
   import clm_round_ctrl_pkg::*;
#(
   parameter int NR          = NR_AES128,
   parameter int WDOG_CYCLES = 64
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   start_i,
   output logic   busy_o,
   output logic   done_o,
   output logic   err_o,
   output logic   init_ark_o,
   output logic   rand_req_o,
   input  logic   rand_ack_i,
   output logic   sb_active_o,
   output logic   sb_load_r_o,
   input  logic   sb_drdy_i,
   output logic   lin_en_o,
   output logic   ks_step_o,
   output logic   last_round_o,
   output round_t round_o
);

   if (NR < 1 || NR > 15) begin : g_bad_nr
      $error("clm_round_ctrl: NR must be 1..15");
   end
   if (WDOG_CYCLES < 2) begin : g_bad_wdog
      $error("clm_round_ctrl: WDOG_CYCLES must be at least 2");
   end

   localparam round_t NR_R = round_t'(NR);

   rctrl_state_t state_q, state_d;
   round_t       round_q, round_d;

`ifdef CLM_RCTRL_WDOG_EN
   logic wdog_expired;

   clm_rctrl_wdog #(
      .WDOG_CYCLES(WDOG_CYCLES)
   ) u_wdog (
      .clk     (clk),
      .rst     (rst),
      .clr     (state_q != SUB),
      .inc     ((state_q == SUB) && !sb_drdy_i),
      .expired (wdog_expired)
   );
`endif

   always_comb begin
      state_d = state_q;
      round_d = round_q;
      unique case (state_q)
         IDLE: if (start_i) state_d = INIT;
         INIT: begin
            round_d = 4'd1;
            state_d = RAND;
         end
         RAND: if (rand_ack_i) state_d = LOAD;
         LOAD: state_d = SUB;
         SUB: begin
            if (sb_drdy_i) state_d = LIN;
`ifdef CLM_RCTRL_WDOG_EN
            else if (wdog_expired) state_d = ERR;
`endif
         end
         LIN: begin
            if (round_q == NR_R) begin
               state_d = DONE;
            end else begin
               round_d = round_q + 4'd1;
               state_d = RAND;
            end
         end
         DONE: begin
            state_d = IDLE;
            round_d = '0;
         end
         ERR: begin
            if (start_i) begin
               state_d = IDLE;
               round_d = '0;
            end
         end
         default: begin
            state_d = IDLE;
            round_d = '0;
         end
      endcase
   end

   // Outputs are registered from the next state, so they equal a Moore decode of state_q.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         round_q     <= '0;
         busy_o      <= 1'b0;
         done_o      <= 1'b0;
         init_ark_o  <= 1'b0;
         rand_req_o  <= 1'b0;
         sb_active_o <= 1'b0;
         sb_load_r_o <= 1'b0;
         lin_en_o    <= 1'b0;
         ks_step_o   <= 1'b0;
`ifdef CLM_RCTRL_WDOG_EN
         err_o       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         round_q     <= round_d;
         busy_o      <= (state_d != IDLE);
         done_o      <= (state_d == DONE);
         init_ark_o  <= (state_d == INIT);
         rand_req_o  <= (state_d == RAND);
         sb_active_o <= (state_d == LOAD) || (state_d == SUB);
         sb_load_r_o <= (state_d == LOAD);
         lin_en_o    <= (state_d == LIN);
         ks_step_o   <= (state_d == LIN);
`ifdef CLM_RCTRL_WDOG_EN
         err_o       <= (state_d == ERR);
`endif
      end
   end

`ifndef CLM_RCTRL_WDOG_EN
   assign err_o = 1'b0;
`endif

   assign last_round_o = (round_q == NR_R);
   assign round_o      = round_q;

endmodule

// File: tb/tb_clm_round_ctrl.sv
// Directed bench for clm_round_ctrl: a phase-level model expands each planned encryption into
// per-cycle inputs and expected outputs, compared every cycle, plus literal latency/count pins.
module tb_clm_round_ctrl;

   localparam int NRB = 10;

   logic       clk = 1'b1;
   logic       rst, start_i, rand_ack_i, sb_drdy_i;
   logic       busy_o, done_o, err_o, init_ark_o, rand_req_o;
   logic       sb_active_o, sb_load_r_o, lin_en_o, ks_step_o, last_round_o;
   logic [3:0] round_o;

   always #5 clk = ~clk;

   clm_round_ctrl #(
      .NR          (NRB),
      .WDOG_CYCLES (8)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .start_i      (start_i),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .err_o        (err_o),
      .init_ark_o   (init_ark_o),
      .rand_req_o   (rand_req_o),
      .rand_ack_i   (rand_ack_i),
      .sb_active_o  (sb_active_o),
      .sb_load_r_o  (sb_load_r_o),
      .sb_drdy_i    (sb_drdy_i),
      .lin_en_o     (lin_en_o),
      .ks_step_o    (ks_step_o),
      .last_round_o (last_round_o),
      .round_o      (round_o)
   );

   typedef struct {
      bit          chk;
      bit          rst;
      bit          start;
      bit          ack;
      bit          drdy;
      logic [13:0] exp;
   } rec_t;

   rec_t q[$];
   int   checks   = 0;
   int   failures = 0;
   int   lin_cnt  = 0;
   int   done_seen[$];

   // Expected output vector: {busy,done,err,init,req,active,load,lin,ks,last,round}
   function automatic logic [13:0] ev(bit busy, bit done, bit err, bit init, bit req,
                                      bit act, bit load, bit lin, int rnd);
      logic [3:0] r4 = 4'(rnd);
      return {busy, done, err, init, req, act, load, lin, lin, (rnd == NRB), r4};
   endfunction

   task automatic push(bit c, bit r, bit s, bit a, bit d, logic [13:0] e);
      rec_t x;
      x.chk = c; x.rst = r; x.start = s; x.ack = a; x.drdy = d; x.exp = e;
      q.push_back(x);
   endtask

   task automatic gen_idle(int n, bit noise);
      for (int k = 0; k < n; k++) push(1, 0, 0, noise, noise, '0);
   endtask

   // One encryption: ack3 extra wait cycles in round 3, s cycles per SUB, optional ignored
   // start pulses, spurious drdy in LOAD of one round, or reset in SUB of abort_r.
   task automatic gen_run(input int ack3, input int s, input int start_sub_r, input bit start_done,
                          input int spur_load_r, input int abort_r,
                          output int st_idx, output int done_idx);
      st_idx   = q.size();
      done_idx = -1;
      push(1, 0, 1, 1, 0, '0);
      push(1, 0, 0, 1, 0, ev(1, 0, 0, 1, 0, 0, 0, 0, 0));
      for (int r = 1; r <= NRB; r++) begin
         int d = (r == 3) ? ack3 : 0;
         for (int k = 0; k <= d; k++) push(1, 0, 0, (k == d), 0, ev(1, 0, 0, 0, 1, 0, 0, 0, r));
         push(1, 0, 0, 1, (r == spur_load_r), ev(1, 0, 0, 0, 0, 1, 1, 0, r));
         for (int k = 1; k <= s; k++) begin
            if (r == abort_r && k == 2) begin
               push(1, 1, 0, 1, 0, ev(1, 0, 0, 0, 0, 1, 0, 0, r));
               push(1, 0, 0, 1, 0, '0);
               return;
            end
            push(1, 0, (r == start_sub_r && k == 2), 1, (k == s), ev(1, 0, 0, 0, 0, 1, 0, 0, r));
         end
         push(1, 0, 0, 1, 0, ev(1, 0, 0, 0, 0, 0, 0, 1, r));
      end
      done_idx = q.size();
      push(1, 0, start_done, 1, 0, ev(1, 1, 0, 0, 0, 0, 0, 0, NRB));
   endtask

`ifdef CLM_RCTRL_WDOG_EN
   task automatic gen_wdog();
      push(1, 0, 1, 1, 0, '0);
      push(1, 0, 0, 1, 0, ev(1, 0, 0, 1, 0, 0, 0, 0, 0));
      push(1, 0, 0, 1, 0, ev(1, 0, 0, 0, 1, 0, 0, 0, 1));
      push(1, 0, 0, 1, 0, ev(1, 0, 0, 0, 0, 1, 1, 0, 1));
      for (int k = 1; k <= 8; k++) push(1, 0, 0, 1, 0, ev(1, 0, 0, 0, 0, 1, 0, 0, 1));
      for (int k = 1; k <= 3; k++) push(1, 0, (k == 3), 1, 0, ev(1, 0, 1, 0, 0, 0, 0, 0, 1));
      gen_idle(3, 0);
   endtask
`endif

   task automatic chk_int(string name, int got, int want);
      checks++;
      if (got != want) begin
         failures++;
         $display("FAIL %s got=%0d want=%0d", name, got, want);
      end
   endtask

   initial begin
      int sa, da, sb, db, sd, dd, se, de;
      logic [13:0] act;

      push(0, 1, 0, 0, 0, '0);
      push(1, 1, 0, 0, 0, '0);
      gen_idle(3, 1);
      gen_run(0, 4, 2, 1, 1, 0, sa, da);
      gen_idle(2, 0);
      gen_run(4, 2, 0, 0, 0, 0, sb, db);
      gen_idle(1, 0);
      gen_run(0, 4, 0, 0, 0, 6, sd, dd);
      gen_idle(2, 1);
      gen_run(0, 1, 0, 0, 0, 0, se, de);
      gen_idle(3, 0);
`ifdef CLM_RCTRL_WDOG_EN
      gen_wdog();
`endif

      // Hand-computed latencies pin the model: 1 + NR*(3+S) + 1 (+ extra ack waits).
      chk_int("model_lat_a", da - sa, 72);
      chk_int("model_lat_b", db - sb, 56);
      chk_int("model_lat_e", de - se, 42);
      chk_int("model_abort_no_done", dd, -1);

      foreach (q[i]) begin
         rst        = q[i].rst;
         start_i    = q[i].start;
         rand_ack_i = q[i].ack;
         sb_drdy_i  = q[i].drdy;
         @(negedge clk);
         if (q[i].chk) begin
            act = {busy_o, done_o, err_o, init_ark_o, rand_req_o, sb_active_o, sb_load_r_o,
                   lin_en_o, ks_step_o, last_round_o, round_o};
            checks++;
            if (act !== q[i].exp) begin
               failures++;
               $display("FAIL cyc%0d outputs got=%b want=%b (busy,done,err,init,req,act,load,lin,ks,last,round)",
                        i, act, q[i].exp);
            end
            if (done_o === 1'b1) done_seen.push_back(i);
            if (lin_en_o === 1'b1) lin_cnt++;
         end
         @(posedge clk);
         #1;
      end

      chk_int("done_pulses", done_seen.size(), 3);
      chk_int("lin_pulses", lin_cnt, 35);
      chk_int("dut_lat_a", (done_seen.size() > 0) ? done_seen[0] - sa : -1, 72);
      chk_int("dut_lat_b", (done_seen.size() > 1) ? done_seen[1] - sb : -1, 56);
      chk_int("dut_lat_e", (done_seen.size() > 2) ? done_seen[2] - se : -1, 42);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
